// File: rtl/prog_mem_arbiter_if.sv
// Request/response bundle between the IF stage, the debug reader, the arbiter and Program_Memory.
interface prog_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [DATA_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_err;

  logic                  dbg_req;
  logic [DATA_WIDTH-1:0] dbg_addr;
  logic                  dbg_gnt;
  logic                  dbg_rvalid;
  logic [DATA_WIDTH-1:0] dbg_rdata;
  logic                  dbg_err;

  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dbg_req, dbg_addr, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err, mem_addr
  );

  modport master (
    output if_req, if_addr, dbg_req, dbg_addr, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err, mem_addr
  );
endinterface

// File: rtl/prog_mem_arbiter.sv
// Shares the instruction ROM read port between fetch (fixed priority) and a debug reader,
// with a starvation counter that forces a debug grant after STARVE_LIMIT denied cycles.
module prog_mem_arbiter #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h00400000,
  parameter int                    STARVE_LIMIT = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = 32'h00000013
) (
  input  logic                   clk,
  input  logic                   reset,
  prog_mem_arbiter_if.slave      bus
);

  typedef enum logic {IF_PRIO = 1'b0, DBG_FORCE = 1'b1} state_t;

  localparam int                    CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]         LIMIT = CW'(STARVE_LIMIT);
  localparam logic [DATA_WIDTH-3:0] DEPTH = (DATA_WIDTH-2)'(MEMORY_DEPTH);

  state_t                state_q, state_d;
  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  if_err_q, if_err_d;
  logic                  dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic                  dbg_err_q, dbg_err_d;

  logic                  if_gnt_c, dbg_gnt_c;
  logic [DATA_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-3:0] off_word;
  logic                  addr_err;
  logic [DATA_WIDTH-1:0] resp_data;

  always_comb begin
    if_gnt_c  = 1'b0;
    dbg_gnt_c = 1'b0;
    if (!reset) begin
      if (state_q == IF_PRIO) begin
        if_gnt_c  = bus.if_req;
        dbg_gnt_c = bus.dbg_req & ~bus.if_req;
      end else begin
        dbg_gnt_c = bus.dbg_req;
        if_gnt_c  = bus.if_req & ~bus.dbg_req;
      end
    end
  end

  // TEXT_BASE is word aligned, so the word offset needs no borrow from the byte bits.
  always_comb begin
    mem_addr_c = dbg_gnt_c ? bus.dbg_addr : bus.if_addr;
    off_word   = mem_addr_c[DATA_WIDTH-1:2] - TEXT_BASE[DATA_WIDTH-1:2];
    addr_err   = (|mem_addr_c[1:0]) | (off_word >= DEPTH);
    resp_data  = addr_err ? NOP_INSTR : bus.mem_rdata;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (dbg_gnt_c) begin
      wait_cnt_d = '0;
    end else if (bus.dbg_req && (wait_cnt_q != LIMIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    case (state_q)
      IF_PRIO: begin
        if (wait_cnt_d == LIMIT) state_d = DBG_FORCE;
      end
      DBG_FORCE: begin
        // Either served or the debug reader gave up; both restart the starvation window.
        if (dbg_gnt_c || !bus.dbg_req) begin
          state_d    = IF_PRIO;
          wait_cnt_d = '0;
        end
      end
      default: state_d = IF_PRIO;
    endcase
  end

  always_comb begin
    if_rvalid_d  = if_gnt_c;
    if_rdata_d   = if_gnt_c ? resp_data : if_rdata_q;
    if_err_d     = if_gnt_c ? addr_err : if_err_q;
    dbg_rvalid_d = dbg_gnt_c;
    dbg_rdata_d  = dbg_gnt_c ? resp_data : dbg_rdata_q;
    dbg_err_d    = dbg_gnt_c ? addr_err : dbg_err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IF_PRIO;
      wait_cnt_q   <= '0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      if_err_q     <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
      dbg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      if_err_q     <= if_err_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_err_q    <= dbg_err_d;
    end
  end

  assign bus.if_gnt     = if_gnt_c;
  assign bus.dbg_gnt    = dbg_gnt_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.if_rvalid  = if_rvalid_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.if_err     = if_err_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.dbg_err    = dbg_err_q;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed bench for prog_mem_arbiter: stimulus pushes expected responses, a monitor pops and compares.
module tb_prog_mem_arbiter;

  localparam logic [31:0] TEXT_BASE = 32'h00400000;
  localparam logic [31:0] NOP       = 32'h00000013;
  localparam logic [31:0] BAD       = 32'hBADBAD00;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  prog_mem_arbiter_if #(.DATA_WIDTH(32)) bus();

  prog_mem_arbiter #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(64),
    .TEXT_BASE   (32'h00400000),
    .STARVE_LIMIT(4),
    .NOP_INSTR   (32'h00000013)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  exp_t if_q[$];
  exp_t dbg_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] rom_val(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  // Combinational ROM; out-of-range reads return a marker distinct from the NOP.
  logic [31:0] env_idx;
  always_comb begin
    env_idx       = (bus.mem_addr - TEXT_BASE) >> 2;
    bus.mem_rdata = (env_idx < 32'd64) ? rom_val(int'(env_idx)) : BAD;
  end

  function automatic exp_t mk(input bit err, input int idx, input string tag);
    exp_t e;
    e.rdata = err ? NOP : rom_val(idx);
    e.err   = err;
    e.tag   = tag;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.if_rvalid) begin
        if (if_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL if_unexpected: got rvalid=1 rdata=%h expected no response", bus.if_rdata);
        end else begin
          mon_e = if_q.pop_front();
          check({mon_e.tag, " if_rdata"}, bus.if_rdata, mon_e.rdata);
          check({mon_e.tag, " if_err"}, {31'b0, bus.if_err}, {31'b0, mon_e.err});
          $display("IF  resp %s rdata=%h err=%0d", mon_e.tag, bus.if_rdata, bus.if_err);
        end
      end
      if (bus.dbg_rvalid) begin
        if (dbg_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dbg_unexpected: got rvalid=1 rdata=%h expected no response", bus.dbg_rdata);
        end else begin
          mon_e = dbg_q.pop_front();
          check({mon_e.tag, " dbg_rdata"}, bus.dbg_rdata, mon_e.rdata);
          check({mon_e.tag, " dbg_err"}, {31'b0, bus.dbg_err}, {31'b0, mon_e.err});
          $display("DBG resp %s rdata=%h err=%0d", mon_e.tag, bus.dbg_rdata, bus.dbg_err);
        end
      end
    end
  end

  // One requester alone for one cycle; a lone request is granted immediately.
  task automatic single(input bit dbg, input logic [31:0] addr, input bit err,
                        input int idx, input string tag);
    if (dbg) begin
      bus.dbg_req  = 1'b1;
      bus.dbg_addr = addr;
      dbg_q.push_back(mk(err, idx, tag));
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
      if_q.push_back(mk(err, idx, tag));
    end
    @(negedge clk);
    check({tag, " own_gnt"}, {31'b0, dbg ? bus.dbg_gnt : bus.if_gnt}, 32'd1);
    check({tag, " other_gnt"}, {31'b0, dbg ? bus.if_gnt : bus.dbg_gnt}, 32'd0);
    tick();
    bus.if_req  = 1'b0;
    bus.dbg_req = 1'b0;
  endtask

  // Both requesters held high; DBG must win on cycle exp_cycle, then IF is regranted.
  task automatic starve(input logic [31:0] ia, input int iidx, input logic [31:0] da,
                        input int didx, input int exp_cycle, input string tag);
    bit got = 1'b0;
    bus.if_req   = 1'b1;
    bus.if_addr  = ia;
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = da;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (bus.dbg_gnt) begin
        got = 1'b1;
        check({tag, " dbg_gnt_cycle"}, 32'(c), 32'(exp_cycle));
        check({tag, " if_gnt_while_dbg"}, {31'b0, bus.if_gnt}, 32'd0);
        dbg_q.push_back(mk(1'b0, didx, tag));
      end else if (bus.if_gnt) begin
        if_q.push_back(mk(1'b0, iidx, tag));
      end
      tick();
      if (got) bus.dbg_req = 1'b0;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s dbg_gnt_timeout: got no grant in 12 cycles expected cycle %0d", tag, exp_cycle);
      bus.dbg_req = 1'b0;
    end
    @(negedge clk);
    check({tag, " if_regrant"}, {31'b0, bus.if_gnt}, 32'd1);
    if (bus.if_gnt) if_q.push_back(mk(1'b0, iidx, tag));
    tick();
    bus.if_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    bus.if_req   = 1'b1;
    bus.if_addr  = TEXT_BASE;
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = TEXT_BASE;
    reset        = 1'b1;

    // Reset state, and no grants while reset is high.
    @(negedge clk);
    check("rst if_gnt", {31'b0, bus.if_gnt}, 32'd0);
    check("rst dbg_gnt", {31'b0, bus.dbg_gnt}, 32'd0);
    check("rst if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
    check("rst dbg_rvalid", {31'b0, bus.dbg_rvalid}, 32'd0);
    check("rst if_rdata", bus.if_rdata, 32'd0);
    check("rst dbg_rdata", bus.dbg_rdata, 32'd0);
    check("rst if_err", {31'b0, bus.if_err}, 32'd0);
    bus.if_req  = 1'b0;
    bus.dbg_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    single(1'b0, 32'h00400004, 1'b0, 1, "t1");
    starve(32'h00400008, 2, 32'h00400000, 0, 5, "t2");
    single(1'b1, 32'h00400002, 1'b1, 0, "t3");
    single(1'b0, 32'h00400100, 1'b1, 0, "t4_word64");
    single(1'b0, 32'h003FFFFC, 1'b1, 0, "t4_below");
    single(1'b0, 32'h004000FC, 1'b0, 63, "t4_last");
    single(1'b1, 32'hFFFFFFFC, 1'b1, 0, "t4_top");
    single(1'b1, 32'h00400001, 1'b1, 0, "t4_mis1");

    // Back-to-back DBG grants: one response per cycle.
    bus.dbg_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.dbg_addr = TEXT_BASE + 32'(4 * k);
      dbg_q.push_back(mk(1'b0, k, "t5"));
      @(negedge clk);
      check("t5 dbg_gnt", {31'b0, bus.dbg_gnt}, 32'd1);
      tick();
    end
    bus.dbg_req = 1'b0;
    tick();

    // Build up some DBG starvation, then reset in the cycle after an IF grant.
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h00400010;
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 32'h00400004;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("t6 pre if_gnt", {31'b0, bus.if_gnt}, 32'd1);
      if (c < 3) if_q.push_back(mk(1'b0, 4, "t6_pre"));
      tick();
    end
    reset = 1'b1;
    #1;
    check("t6 if_rvalid_killed", {31'b0, bus.if_rvalid}, 32'd0);
    check("t6 dbg_rvalid", {31'b0, bus.dbg_rvalid}, 32'd0);
    check("t6 wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
    check("t6 gnt_in_reset", {30'b0, bus.if_gnt, bus.dbg_gnt}, 32'd0);
    bus.if_req  = 1'b0;
    bus.dbg_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    // A full starvation window again proves the counter and state were cleared.
    starve(32'h00400010, 4, 32'h00400004, 1, 5, "t6_post");

    tick();
    tick();
    check("end if_q_empty", 32'(if_q.size()), 32'd0);
    check("end dbg_q_empty", 32'(dbg_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
